// File: rtl/if_buf_if.sv
// Fetch-to-decode instruction buffer bus: fetch result and pipeline
// controls in, show-ahead head entry and fill status out.
interface if_buf_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  // Fetch response and pipeline control into the buffer
  logic          valid_i;
  logic [31:0]   pc_i;
  logic [31:0]   inst_i;
  logic [31:0]   next_pc_i;
  logic          next_taken_i;
  logic          flush_i;
  logic          branch_redirect_i;
  logic          stall_id_i;

  // Head entry and occupancy out of the buffer
  logic          valid_o;
  logic [31:0]   pc_o;
  logic [31:0]   inst_o;
  logic [31:0]   next_pc_o;
  logic          next_taken_o;
  logic          stall_req_o;
  logic [CW-1:0] count_o;

  // Surrounding pipeline: drives fetch results and controls, consumes the head
  modport master (
    output valid_i, pc_i, inst_i, next_pc_i, next_taken_i,
    output flush_i, branch_redirect_i, stall_id_i,
    input  valid_o, pc_o, inst_o, next_pc_o, next_taken_o,
    input  stall_req_o, count_o
  );

  // The buffer itself
  modport slave (
    input  valid_i, pc_i, inst_i, next_pc_i, next_taken_i,
    input  flush_i, branch_redirect_i, stall_id_i,
    output valid_o, pc_o, inst_o, next_pc_o, next_taken_o,
    output stall_req_o, count_o
  );
endinterface

// File: rtl/if_buf.sv
// Instruction fetch buffer: circular show-ahead FIFO between fetch and decode,
// emptied on flush or branch redirect, with early stall request to fetch.
module if_buf #(
  parameter int unsigned DEPTH    = 4,           // power of two, 2..16
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic      ck_i,
  input  logic      rs_n_i,
  if_buf_if.slave   bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] next_pc;
    logic        next_taken;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          wr_entry;
  entry_t          head;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            kill;
  logic            full;
  logic            head_valid;
  logic            push;
  logic            pop;

  // Queue control: a kill discards both the queue and the in-flight fetch
  always_comb begin
    kill       = bus.flush_i | bus.branch_redirect_i;
    full       = (count == CW'(DEPTH));
    head_valid = (count != '0);
    pop        = head_valid & ~bus.stall_id_i & ~kill;
    push       = bus.valid_i & ~kill & (~full | pop);
  end

  assign wr_entry = '{
    pc:         bus.pc_i,
    inst:       bus.inst_i,
    next_pc:    bus.next_pc_i,
    next_taken: bus.next_taken_i
  };

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge ck_i or negedge rs_n_i) begin
    if (!rs_n_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (kill) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is never cleared; head_valid gates anything stale
  always_ff @(posedge ck_i) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Show-ahead head: read straight from storage, never bypassed from inputs
  always_comb begin
    head             = mem[rd_ptr];
    bus.valid_o      = 1'b0;
    bus.pc_o         = '0;
    bus.inst_o       = NOP_INST;
    bus.next_pc_o    = '0;
    bus.next_taken_o = 1'b0;
    if (head_valid) begin
      bus.valid_o      = 1'b1;
      bus.pc_o         = head.pc;
      bus.inst_o       = head.inst;
      bus.next_pc_o    = head.next_pc;
      bus.next_taken_o = head.next_taken;
    end
  end

  // Stall one slot early: a fetch already issued from the registered PC still lands
  assign bus.stall_req_o = (count >= CW'(DEPTH - 1));
  assign bus.count_o     = count;

endmodule

// File: tb/tb_if_buf.sv
// Directed bench for if_buf: reset, show-ahead timing, fill/drain, full
// push+pop, kill behaviour, pointer wrap and asynchronous reset.
module tb_if_buf;

  logic ck_i;
  logic rs_n_i;
  int   total;
  int   bad;

  if_buf_if #(.DEPTH(4)) bus ();

  if_buf #(.DEPTH(4), .NOP_INST(32'h00000013)) dut (
    .ck_i   (ck_i),
    .rs_n_i (rs_n_i),
    .bus    (bus)
  );

  initial ck_i = 1'b0;
  always #5 ck_i = ~ck_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge ck_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic [31:0] npc, input logic tk);
    bus.valid_i      = v;
    bus.pc_i         = pc;
    bus.inst_i       = inst;
    bus.next_pc_i    = npc;
    bus.next_taken_i = tk;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic push_pc(input logic [31:0] pc);
    drive(1'b1, pc, 32'h10000000 | pc, pc + 32'h4, 1'b0);
  endtask

  task automatic check_empty(input string tag);
    check({tag, ".valid"}, 32'(bus.valid_o), 32'd0);
    check({tag, ".inst"},  bus.inst_o, 32'h00000013);
    check({tag, ".pc"},    bus.pc_o, 32'h0);
    check({tag, ".npc"},   bus.next_pc_o, 32'h0);
    check({tag, ".tk"},    32'(bus.next_taken_o), 32'd0);
    check({tag, ".cnt"},   32'(bus.count_o), 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rs_n_i = 1'b0;
    idle();
    bus.flush_i           = 1'b0;
    bus.branch_redirect_i = 1'b0;
    bus.stall_id_i        = 1'b0;

    // Reset state
    #3;
    check_empty("rst");
    check("rst.sreq", 32'(bus.stall_req_o), 32'd0);
    tick();
    rs_n_i = 1'b1;

    // Single push: visible one cycle later, consumed the cycle after
    drive(1'b1, 32'h80000000, 32'h00500093, 32'h80000004, 1'b0);
    tick();
    idle();
    check("one.valid", 32'(bus.valid_o), 32'd1);
    check("one.pc",    bus.pc_o, 32'h80000000);
    check("one.inst",  bus.inst_o, 32'h00500093);
    check("one.npc",   bus.next_pc_o, 32'h80000004);
    check("one.cnt",   32'(bus.count_o), 32'd1);
    tick();
    check_empty("one.drain");

    // Fill with decode stalled; fifth push is dropped
    bus.stall_id_i = 1'b1;
    push_pc(32'h0); tick();
    check("fill1.cnt",  32'(bus.count_o), 32'd1);
    push_pc(32'h4); tick();
    check("fill2.sreq", 32'(bus.stall_req_o), 32'd0);
    push_pc(32'h8); tick();
    check("fill3.cnt",  32'(bus.count_o), 32'd3);
    check("fill3.sreq", 32'(bus.stall_req_o), 32'd1);
    push_pc(32'hC); tick();
    check("fill4.cnt",  32'(bus.count_o), 32'd4);
    push_pc(32'h10); tick();
    check("drop.cnt",   32'(bus.count_o), 32'd4);
    check("drop.head",  bus.pc_o, 32'h0);
    idle();
    bus.stall_id_i = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("drain%0d.pc", k),   bus.pc_o, 32'(k * 4));
      check($sformatf("drain%0d.inst", k), bus.inst_o, 32'h10000000 | 32'(k * 4));
      check($sformatf("drain%0d.cnt", k),  32'(bus.count_o), 32'(4 - k));
    end
    tick();
    check_empty("drain.end");

    // Full queue with simultaneous push and pop
    bus.stall_id_i = 1'b1;
    push_pc(32'h0); tick();
    push_pc(32'h4); tick();
    push_pc(32'h8); tick();
    push_pc(32'hC); tick();
    bus.stall_id_i = 1'b0;
    push_pc(32'h10); tick();
    idle();
    check("fullpp.cnt",  32'(bus.count_o), 32'd4);
    check("fullpp.head", bus.pc_o, 32'h4);
    tick(); check("fullpp.pc8",  bus.pc_o, 32'h8);
    tick(); check("fullpp.pcC",  bus.pc_o, 32'hC);
    tick(); check("fullpp.pc10", bus.pc_o, 32'h10);
    check("fullpp.last", bus.inst_o, 32'h10000010);
    tick();
    check_empty("fullpp.end");

    // Redirect with three queued, decode stalled, and a fetch arriving
    bus.stall_id_i = 1'b1;
    push_pc(32'h20); tick();
    push_pc(32'h24); tick();
    push_pc(32'h28); tick();
    check("redir.pre", 32'(bus.count_o), 32'd3);
    push_pc(32'h99);
    bus.branch_redirect_i = 1'b1;
    tick();
    bus.branch_redirect_i = 1'b0;
    check_empty("redir");
    check("redir.sreq",  32'(bus.stall_req_o), 32'd0);
    check("redir.rdptr", 32'(dut.rd_ptr), 32'd0);
    check("redir.wrptr", 32'(dut.wr_ptr), 32'd0);
    push_pc(32'h40); tick();
    idle();
    check("redir.next.pc",  bus.pc_o, 32'h40);
    check("redir.next.cnt", 32'(bus.count_o), 32'd1);
    check("redir.next.wr",  32'(dut.wr_ptr), 32'd1);

    // Flush and redirect together
    push_pc(32'h44); tick();
    push_pc(32'h48);
    bus.flush_i           = 1'b1;
    bus.branch_redirect_i = 1'b1;
    tick();
    bus.flush_i           = 1'b0;
    bus.branch_redirect_i = 1'b0;
    idle();
    check_empty("both");

    // Streaming through 20 entries with pointer wrap
    bus.stall_id_i = 1'b0;
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 32'h1000 + 32'(k * 4), 32'hA0000000 + 32'(k),
            32'h2000 + 32'(k * 8), k[0]);
      tick();
      check($sformatf("strm%0d.pc", k),  bus.pc_o, 32'h1000 + 32'(k * 4));
      check($sformatf("strm%0d.npc", k), bus.next_pc_o, 32'h2000 + 32'(k * 8));
      check($sformatf("strm%0d.tk", k),  32'(bus.next_taken_o), 32'(k[0]));
      check($sformatf("strm%0d.in", k),  bus.inst_o, 32'hA0000000 + 32'(k));
      check($sformatf("strm%0d.cnt", k), 32'(bus.count_o), 32'd1);
    end
    idle();
    tick();
    check_empty("strm.end");

    // Asynchronous reset mid-cycle with two entries queued
    bus.stall_id_i = 1'b1;
    push_pc(32'h60); tick();
    push_pc(32'h64); tick();
    idle();
    check("arst.pre", 32'(bus.count_o), 32'd2);
    #2;
    rs_n_i = 1'b0;
    #1;
    check("arst.valid", 32'(bus.valid_o), 32'd0);
    check("arst.cnt",   32'(bus.count_o), 32'd0);
    check("arst.inst",  bus.inst_o, 32'h00000013);
    tick();
    // First edge after release accepts a fetch into entry 0
    rs_n_i = 1'b1;
    push_pc(32'h500);
    tick();
    idle();
    check("rel.pc",  bus.pc_o, 32'h500);
    check("rel.cnt", 32'(bus.count_o), 32'd1);
    check("rel.wr",  32'(dut.wr_ptr), 32'd1);
    check("rel.rd",  32'(dut.rd_ptr), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
